// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit.
//   state_e   : sequencer states (fetch, execute, memory, halt)
//   ctrl_t    : datapath control word produced by the decoder
//   pc_sel_e  : next-PC source selected by the decoder
//   Op*/Fs*   : opcode patterns and ALU function codes
//   Stat*     : bit positions inside the ALU status word {V,C,N,Z}
package legv8_ctrl_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StMem   = 2'd2,
    StHalt  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PcHold   = 2'd0,
    PcSeq    = 2'd1,
    PcBranch = 2'd2
  } pc_sel_e;

  // 11-bit opcodes, IR[31:21]
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  // 10-bit opcodes, IR[31:22]
  localparam logic [9:0]  OpAddi = 10'b1001000100;
  localparam logic [9:0]  OpSubi = 10'b1101000100;
  // 8-bit opcode, IR[31:24]
  localparam logic [7:0]  OpCbz  = 8'b10110100;
  // 6-bit opcode, IR[31:26]
  localparam logic [5:0]  OpB    = 6'b000101;

  localparam logic [4:0] FsAnd = 5'b00000;
  localparam logic [4:0] FsOrr = 5'b00100;
  localparam logic [4:0] FsAdd = 5'b01000;
  localparam logic [4:0] FsSub = 5'b01010;

  localparam int unsigned StatZ = 0;
  localparam int unsigned StatN = 1;
  localparam int unsigned StatC = 2;
  localparam int unsigned StatV = 3;

  localparam logic [4:0] Xzr = 5'd31;

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        wr;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        m;
    logic        en_alu;
    logic        en_b;
    logic        en_addr_alu;
    logic        rcs;
    logic        rwe;
    logic        roe;
    logic        ireq;
    logic        halted;
  } ctrl_t;

  function automatic logic [63:0] sext9(logic [8:0] v);
    return {{55{v[8]}}, v};
  endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational control decoder: state + instruction register + Z flag in,
// datapath control word and next-PC selection out.
//   state_i   : current sequencer state
//   ir_i      : latched instruction word
//   stat_z_i  : ALU zero flag (CBZ condition)
//   ctrl_o    : control word (register selects, ALU function, enables, RAM strobes)
//   pc_sel_o  : hold / PC+4 / PC+br_ofs_o
//   br_ofs_o  : byte offset for taken branches
//   to_mem_o  : instruction needs the extra MEM cycle (LDUR)
module legv8_decoder
  import legv8_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [31:0] ir_i,
  input  logic        stat_z_i,
  output ctrl_t       ctrl_o,
  output pc_sel_e     pc_sel_o,
  output logic [63:0] br_ofs_o,
  output logic        to_mem_o
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [11:0] imm12;
  logic [8:0]  dt9;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic        is_rtype;
  logic        is_itype;
  ctrl_t       mem_addr;

  assign op11  = ir_i[31:21];
  assign op10  = ir_i[31:22];
  assign op8   = ir_i[31:24];
  assign op6   = ir_i[31:26];
  assign rd    = ir_i[4:0];
  assign rn    = ir_i[9:5];
  assign rm    = ir_i[20:16];
  assign imm12 = ir_i[21:10];
  assign dt9   = ir_i[20:12];
  assign imm19 = ir_i[23:5];
  assign imm26 = ir_i[25:0];

  assign is_rtype = (op11 == OpAdd) || (op11 == OpSub) || (op11 == OpAnd) || (op11 == OpOrr);
  assign is_itype = (op10 == OpAddi) || (op10 == OpSubi);

  // Base+offset RAM address drive shared by LDUR (both cycles) and STUR
  always_comb begin
    mem_addr             = '0;
    mem_addr.sa          = rn;
    mem_addr.m           = 1'b1;
    mem_addr.k           = sext9(dt9);
    mem_addr.fs          = FsAdd;
    mem_addr.en_addr_alu = 1'b1;
    mem_addr.rcs         = 1'b1;
    mem_addr.roe         = 1'b1;
  end

  always_comb begin
    ctrl_o   = '0;
    pc_sel_o = PcHold;
    br_ofs_o = '0;
    to_mem_o = 1'b0;
    unique case (state_i)
      StFetch: ctrl_o.ireq = 1'b1;
      StHalt:  ctrl_o.halted = 1'b1;
      StExec: begin
        pc_sel_o = PcSeq;
        if (is_rtype) begin
          ctrl_o.sa     = rn;
          ctrl_o.sb     = rm;
          ctrl_o.da     = rd;
          ctrl_o.wr     = 1'b1;
          ctrl_o.en_alu = 1'b1;
          unique case (op11)
            OpAdd:   ctrl_o.fs = FsAdd;
            OpSub: begin
              ctrl_o.fs = FsSub;
              ctrl_o.c0 = 1'b1;
            end
            OpAnd:   ctrl_o.fs = FsAnd;
            default: ctrl_o.fs = FsOrr;
          endcase
        end else if (is_itype) begin
          ctrl_o.sa     = rn;
          ctrl_o.sb     = rm;
          ctrl_o.da     = rd;
          ctrl_o.wr     = 1'b1;
          ctrl_o.en_alu = 1'b1;
          ctrl_o.m      = 1'b1;
          ctrl_o.k      = {52'b0, imm12};
          ctrl_o.fs     = (op10 == OpSubi) ? FsSub : FsAdd;
          ctrl_o.c0     = (op10 == OpSubi);
        end else if (op11 == OpLdur) begin
          ctrl_o   = mem_addr;
          to_mem_o = 1'b1;
          pc_sel_o = PcHold;  // PC advances when MEM completes
        end else if (op11 == OpStur) begin
          ctrl_o      = mem_addr;
          ctrl_o.roe  = 1'b0;
          ctrl_o.sb   = rd;
          ctrl_o.en_b = 1'b1;
          ctrl_o.rwe  = 1'b1;
        end else if (op8 == OpCbz) begin
          // Rt + XZR through the ALU so Z reflects Rt == 0
          ctrl_o.sa = Xzr;
          ctrl_o.sb = rd;
          ctrl_o.fs = FsAdd;
          if (stat_z_i) begin
            pc_sel_o = PcBranch;
            br_ofs_o = {{43{imm19[18]}}, imm19, 2'b00};
          end
        end else if (op6 == OpB) begin
          pc_sel_o = PcBranch;
          br_ofs_o = {{36{imm26[25]}}, imm26, 2'b00};
        end
      end
      StMem: begin
        pc_sel_o  = PcSeq;
        ctrl_o    = mem_addr;
        ctrl_o.da = rd;
        ctrl_o.wr = 1'b1;
      end
      default: ;
    endcase
    // XZR is never written
    if (ctrl_o.da == Xzr) ctrl_o.wr = 1'b0;
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit. Fetches instructions over an IREQ/IRDY
// handshake, holds them in IR, sequences the datapath control word and owns PC.
//   CLK, RST              : clock (rising edge), asynchronous active-low reset
//   IADDR, IREQ           : fetch address (= PC) and request
//   IRDY, IDATA           : instruction valid and word
//   STAT                  : ALU status {V,C,N,Z}
//   SA, SB, DA, WR        : register-file selects and write enable
//   FS, C0, K, M          : ALU function, carry-in, constant, K/BBUS mux select
//   EN_ALU, EN_B, EN_ADDR_ALU : bus drive enables
//   RCS, RWE, ROE         : RAM strobes
//   HALTED                : high in the halt state
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [63:0] IADDR,
  output logic        IREQ,
  input  logic        IRDY,
  input  logic [31:0] IDATA,
  input  logic [3:0]  STAT,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic        WR,
  output logic [4:0]  FS,
  output logic        C0,
  output logic [63:0] K,
  output logic        M,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_ADDR_ALU,
  output logic        RCS,
  output logic        RWE,
  output logic        ROE,
  output logic        HALTED
);

  state_e      state_q;
  logic [63:0] pc_q;
  logic [31:0] ir_q;
  logic [63:0] pc_next;
  ctrl_t       ctrl;
  pc_sel_e     pc_sel;
  logic [63:0] br_ofs;
  logic        to_mem;
  logic        unused_stat;

  assign unused_stat = ^{STAT[StatV], STAT[StatC], STAT[StatN]};

  legv8_decoder u_decoder (
    .state_i  (state_q),
    .ir_i     (ir_q),
    .stat_z_i (STAT[StatZ]),
    .ctrl_o   (ctrl),
    .pc_sel_o (pc_sel),
    .br_ofs_o (br_ofs),
    .to_mem_o (to_mem)
  );

  always_comb begin
    unique case (pc_sel)
      PcSeq:    pc_next = pc_q + 64'd4;
      PcBranch: pc_next = pc_q + br_ofs;
      default:  pc_next = pc_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StFetch;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
    end else begin
      pc_q <= pc_next;
      unique case (state_q)
        StFetch: begin
          if (IRDY) begin
            ir_q    <= IDATA;
            state_q <= (IDATA == 32'h0) ? StHalt : StExec;
          end
        end
        StExec:  state_q <= to_mem ? StMem : StFetch;
        StMem:   state_q <= StFetch;
        default: state_q <= StHalt;  // left only through reset
      endcase
    end
  end

  assign IADDR       = pc_q;
  assign IREQ        = ctrl.ireq;
  assign HALTED      = ctrl.halted;
  assign SA          = ctrl.sa;
  assign SB          = ctrl.sb;
  assign DA          = ctrl.da;
  assign WR          = ctrl.wr;
  assign FS          = ctrl.fs;
  assign C0          = ctrl.c0;
  assign K           = ctrl.k;
  assign M           = ctrl.m;
  assign EN_ALU      = ctrl.en_alu;
  assign EN_B        = ctrl.en_b;
  assign EN_ADDR_ALU = ctrl.en_addr_alu;
  assign RCS         = ctrl.rcs;
  assign RWE         = ctrl.rwe;
  assign ROE         = ctrl.roe;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench: the driver builds instructions from chosen fields, predicts
// the outputs of every execute cycle and the PC seen in the following fetch,
// and queues them; the monitor compares whenever the unit is busy (IREQ low)
// or has just returned to fetch.
module tb_legv8_control_unit;

  typedef enum int {
    KAdd, KSub, KAnd, KOrr, KAddi, KSubi, KLdur, KStur, KCbz, KB, KNop, KHalt
  } kind_e;

  typedef struct packed {
    logic [63:0] iaddr;
    logic        ireq;
    logic        halted;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        wr;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        m;
    logic        en_alu;
    logic        en_b;
    logic        en_addr_alu;
    logic        rcs;
    logic        rwe;
    logic        roe;
  } obs_t;

  logic        CLK;
  logic        RST;
  logic [63:0] IADDR;
  logic        IREQ;
  logic        IRDY;
  logic [31:0] IDATA;
  logic [3:0]  STAT;
  logic [4:0]  SA, SB, DA, FS;
  logic        WR, C0, M, EN_ALU, EN_B, EN_ADDR_ALU, RCS, RWE, ROE, HALTED;
  logic [63:0] K;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];
  logic [63:0] model_pc;

  legv8_control_unit #(.PC_RESET(64'h0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IADDR       (IADDR),
    .IREQ        (IREQ),
    .IRDY        (IRDY),
    .IDATA       (IDATA),
    .STAT        (STAT),
    .SA          (SA),
    .SB          (SB),
    .DA          (DA),
    .WR          (WR),
    .FS          (FS),
    .C0          (C0),
    .K           (K),
    .M           (M),
    .EN_ALU      (EN_ALU),
    .EN_B        (EN_B),
    .EN_ADDR_ALU (EN_ADDR_ALU),
    .RCS         (RCS),
    .RWE         (RWE),
    .ROE         (ROE),
    .HALTED      (HALTED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic obs_t sample();
    obs_t o;
    o.iaddr = IADDR; o.ireq = IREQ; o.halted = HALTED;
    o.sa = SA; o.sb = SB; o.da = DA; o.wr = WR; o.fs = FS; o.c0 = C0; o.k = K; o.m = M;
    o.en_alu = EN_ALU; o.en_b = EN_B; o.en_addr_alu = EN_ADDR_ALU;
    o.rcs = RCS; o.rwe = RWE; o.roe = ROE;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per busy cycle and one on return to fetch.
  initial begin
    bit   prev_busy = 0;
    bit   in_halt = 0;
    obs_t halt_ref = '0;
    obs_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_busy = 0;
        in_halt = 0;
      end else if (in_halt) begin
        check("halt_hold", sample(), halt_ref);
      end else if (!IREQ || prev_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h required no activity", sample());
        end else begin
          e = exp_q.pop_front();
          check(e.ireq ? "fetch_pc" : "exec_word", sample(), e);
          if (e.halted) begin
            in_halt = 1;
            halt_ref = e;
          end
        end
        prev_busy = !IREQ;
      end
    end
  end

  function automatic longint sx(input longint v, input int bits);
    return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
  endfunction

  task automatic issue(input kind_e kd, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [25:0] imm, input int dly,
                       input logic z);
    logic [31:0] w;
    logic [5:0]  sh;
    obs_t        ex, ex2, fe;
    logic [63:0] next_pc;
    longint      off;
    int          n;
    n = 0;
    while (!IREQ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!IREQ) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_wait: IREQ=%b required 1 within 20 cycles", IREQ);
    end
    sh = 6'($urandom);
    case (kd)
      KAdd:    w = {11'b10001011000, rm, sh, rn, rd};
      KSub:    w = {11'b11001011000, rm, sh, rn, rd};
      KAnd:    w = {11'b10001010000, rm, sh, rn, rd};
      KOrr:    w = {11'b10101010000, rm, sh, rn, rd};
      KAddi:   w = {10'b1001000100, imm[11:0], rn, rd};
      KSubi:   w = {10'b1101000100, imm[11:0], rn, rd};
      KLdur:   w = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      KStur:   w = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      KCbz:    w = {8'b10110100, imm[18:0], rd};
      KB:      w = {6'b000101, imm};
      KNop:    w = {3'b011, 29'($urandom)};
      default: w = 32'h0;
    endcase

    ex = '0;
    ex.iaddr = model_pc;
    next_pc = model_pc + 64'd4;
    case (kd)
      KAdd, KSub, KAnd, KOrr: begin
        ex.sa = rn; ex.sb = rm; ex.da = rd; ex.wr = (rd != 5'd31); ex.en_alu = 1'b1;
        ex.fs = (kd == KAdd) ? 5'b01000 : (kd == KSub) ? 5'b01010 :
                (kd == KAnd) ? 5'b00000 : 5'b00100;
        ex.c0 = (kd == KSub);
      end
      KAddi, KSubi: begin
        ex.sa = rn; ex.sb = imm[10:6]; ex.da = rd; ex.wr = (rd != 5'd31);
        ex.en_alu = 1'b1; ex.m = 1'b1; ex.k = 64'(imm[11:0]);
        ex.fs = (kd == KSubi) ? 5'b01010 : 5'b01000;
        ex.c0 = (kd == KSubi);
      end
      KLdur, KStur: begin
        off = sx(longint'(imm[8:0]), 9);
        ex.sa = rn; ex.m = 1'b1; ex.k = 64'(off); ex.fs = 5'b01000;
        ex.en_addr_alu = 1'b1; ex.rcs = 1'b1;
        if (kd == KLdur) begin
          ex.roe = 1'b1;
          ex2 = ex;
          ex2.da = rd;
          ex2.wr = (rd != 5'd31);
        end else begin
          ex.sb = rd; ex.en_b = 1'b1; ex.rwe = 1'b1;
        end
      end
      KCbz: begin
        ex.sa = 5'd31; ex.sb = rd; ex.fs = 5'b01000;
        if (z) next_pc = model_pc + 64'(sx(longint'(imm[18:0]), 19) * 4);
      end
      KB: next_pc = model_pc + 64'(sx(longint'(imm), 26) * 4);
      KHalt: begin
        ex.halted = 1'b1;
        next_pc = model_pc;
      end
      default: ;
    endcase
    fe = '0;
    fe.iaddr = next_pc;
    fe.ireq = 1'b1;

    IDATA = w;
    STAT = {3'($urandom), z};
    if (dly > 0) begin
      IRDY = 1'b0;
      repeat (dly) @(negedge CLK);
    end
    IRDY = 1'b1;
    exp_q.push_back(ex);
    if (kd == KLdur) exp_q.push_back(ex2);
    if (kd != KHalt) exp_q.push_back(fe);
    model_pc = next_pc;
    @(negedge CLK);
    IRDY = 1'($urandom_range(0, 1));  // sometimes leave IRDY high through execute
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rst_word;
    rst_word = '0;
    rst_word.ireq = 1'b1;
    RST = 1'b0;
    IRDY = 1'b0;
    IDATA = '0;
    STAT = '0;
    model_pc = 64'h0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check("reset_state", sample(), rst_word);

    issue(KAddi, 5'd1, 5'd31, 5'd0, 26'd5, 3, 1'b0);        // ADDI X1,X31,#5
    issue(KLdur, 5'd2, 5'd1, 5'd0, 26'h1F8, 0, 1'b0);       // LDUR X2,[X1,#-8]
    issue(KCbz, 5'd3, 5'd0, 5'd0, 26'd4, 1, 1'b1);          // CBZ X3,+16 taken
    issue(KCbz, 5'd3, 5'd0, 5'd0, 26'd4, 0, 1'b0);          // not taken
    issue(KAdd, 5'd31, 5'd4, 5'd5, 26'd0, 0, 1'b0);         // ADD XZR: no write
    issue(KSubi, 5'd9, 5'd10, 5'd0, 26'hFFF, 2, 1'b0);
    issue(KStur, 5'd7, 5'd8, 5'd0, 26'd16, 0, 1'b0);        // now mid-EXEC of STUR

    #1 RST = 1'b0;
    IRDY = 1'b0;
    #1;
    check_bit("stur_reset_rwe", RWE, 1'b0);
    check_bit("stur_reset_rcs", RCS, 1'b0);
    check_bit("stur_reset_en_b", EN_B, 1'b0);
    exp_q.delete();
    model_pc = 64'h0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check("reset_after_stur", sample(), rst_word);

    issue(KB, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF, 0, 1'b0);     // B -1 from PC 0 wraps

    repeat (300) begin
      issue(kind_e'($urandom_range(0, 10)), 5'($urandom), 5'($urandom), 5'($urandom),
            26'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    issue(KHalt, 5'd0, 5'd0, 5'd0, 26'd0, 1, 1'b0);
    repeat (8) begin
      IDATA = $urandom;
      IRDY = 1'b1;
      @(negedge CLK);
    end
    IRDY = 1'b0;
    @(negedge CLK);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/legv8_control_unit.md
# legv8_control_unit

Multi-cycle LEGv8 control unit that sits directly upstream of the 64-bit datapath (register file, ALU, data RAM). It fetches 32-bit instructions over a request/ready handshake and holds them in an instruction register. It then sequences the datapath control word (register selects, ALU function, bus enables, RAM strobes) one state per cycle, and owns the 64-bit program counter, updating it from STAT and the branch offsets.

## Interface
Parameters:
- PC_RESET, 64'h0, PC value loaded on reset

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; asynchronous, active-low
- IADDR  out  64  instruction address (= PC)
- IREQ  out  1  fetch request
- IRDY  in  1  instruction valid on IDATA
- IDATA  in  32  instruction word
- STAT  in  4  ALU status {V,C,N,Z}; Z = STAT[0]
- SA, SB, DA  out  5  A-read, B-read and write register selects
- WR  out  1  register-file write enable
- FS  out  5  ALU function select
- C0  out  1  ALU carry-in
- K  out  64  constant to datapath mux
- M  out  1  datapath mux select: 1 = K, 0 = BBUS
- EN_ALU, EN_B, EN_ADDR_ALU  out  1  tri-state enables (ALU→DBUS, BBUS→DBUS, ALU→RAM address)
- RCS, RWE, ROE  out  1  RAM chip select, write enable, output enable (all active-high)
- HALTED  out  1  high in HALT state

## Operation
- States: FETCH, EXEC, MEM, HALT. Reset state is FETCH.
- FETCH:
  - IREQ=1; on a rising edge with IRDY=1, IR←IDATA and go to EXEC. Otherwise stay.
  - IDATA==32'h0 goes to HALT instead of EXEC.
- Field extraction: Rd/Rt=IR[4:0], Rn=IR[9:5], Rm=IR[20:16], imm12=IR[21:10], dt9=IR[20:12], imm19=IR[23:5], imm26=IR[25:0].
- EXEC, by opcode:
  - ADD/SUB/AND/ORR (11-bit opcodes 10001011000/11001011000/10001010000/10101010000): SA=Rn, SB=Rm, M=0, DA=Rd, WR=1, EN_ALU=1. PC+=4; next state FETCH.
  - ADDI/SUBI (10-bit opcodes 1001000100/1101000100): as R-type but M=1, K=zero-extended imm12.
  - LDUR (11111000010):
    - EXEC: SA=Rn, M=1, K=sign-extended dt9, FS=ADD, EN_ADDR_ALU=1, RCS=1, ROE=1. Next state MEM.
    - MEM: holds the EXEC address drive plus RCS=1, ROE=1, with DA=Rt, WR=1, EN_ALU=0, EN_B=0. PC+=4; next state FETCH.
  - STUR (11111000000): SA=Rn, SB=Rt, M=1, K=sext(dt9), FS=ADD, EN_ADDR_ALU=1, EN_B=1, RCS=1, RWE=1, WR=0. PC+=4.
  - CBZ (8-bit opcode 10110100): SA=31, SB=Rt, M=0, FS=ADD, C0=0. If STAT[0]=1 then PC+=sext(imm19)<<2, else PC+=4.
  - B (6-bit opcode 000101): no datapath strobes. PC+=sext(imm26)<<2.
  - Any other opcode: NOP. All strobes 0; PC+=4.
- FS codes: AND=5'b00000, ORR=5'b00100, ADD=5'b01000, SUB=5'b01010 with C0=1. All other instructions use C0=0.
- Writes to DA=31 (XZR) are suppressed: WR forced 0.
- HALT: all strobes 0, IREQ=0, HALTED=1. Exited only by reset.

## Timing
- All control outputs are combinational from state+IR. In FETCH and HALT, every strobe (WR, EN_*, RCS, RWE, ROE) is 0.
- Reset values:
  - PC=PC_RESET, IR=0, state FETCH.
  - IREQ=1 after reset release. SA/SB/DA/FS/K/M/C0=0, HALTED=0.
- Latency:
  - R/I/STUR/CBZ/B: FETCH wait + 1 EXEC cycle.
  - LDUR: FETCH wait + 2 cycles.
  - Register and RAM writes commit on the edge that ends EXEC (or MEM for LDUR).
- PC updates on the edge that leaves EXEC (MEM for LDUR); arithmetic is modulo 2^64, and wrap from 2^64-4 to 0 is legal.
- IRDY is ignored outside FETCH. IRDY held high continuously gives back-to-back instructions.
- Asserting RST in any state immediately forces the reset values. An in-flight STUR/LDUR is abandoned and strobes drop asynchronously.

## Structure
- Package legv8_ctrl_pkg: opcode constants, FS codes, state enum, STAT bit indices.
- Sub-module legv8_decoder: combinational IR+state+STAT → control word and next-PC select. legv8_control_unit holds PC, IR and the state register.

## Test plan
- Reset: RST low mid-EXEC of a STUR → RWE/RCS/EN_B drop at once. After RST high: PC=0, IREQ=1, all strobes 0.
- ADDI X1,X31,#5 (IDATA=32'h910017E1), IRDY after 3 cycles → IR latched, one EXEC cycle with SA=31, M=1, K=5, FS=5'b01000, DA=1, WR=1. PC=4 afterwards.
- LDUR X2,[X1,#-8] → EXEC K=64'hFFFF_FFFF_FFFF_FFF8, ROE=1, EN_ADDR_ALU=1, WR=0. MEM: WR=1, DA=2. Total 2 cycles after fetch.
- CBZ X3,+16 (imm19=4) with STAT[0]=1 → PC advances by 16. Same instruction with STAT[0]=0 → PC advances by 4.
- B -1 at PC=0 → PC=64'hFFFF_FFFF_FFFF_FFFC (wrap). ADD with Rd=31 → WR stays 0.
- IDATA=0 → HALTED=1, IREQ=0, no further fetches until reset.
